// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the dot-product MAC; MAC_SAT_EN turns wrapping adds into saturating adds.
// Helpers work on XW-bit containers with a run-time field width so any ACC_WIDTH below XW can use them.
package mac_pkg;

    localparam int XW = 64;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} mac_state_t;

    function automatic logic [XW-1:0] low_mask(input int unsigned w);
        return ~({XW{1'b1}} << w);
    endfunction

    // Extends a pw-bit product held in the low bits of p across the whole container.
    function automatic logic [XW-1:0] ext_prod(input logic [XW-1:0] p,
                                               input int unsigned  pw,
                                               input logic         sgn);
        logic [XW-1:0] m;
        logic          msb;
        m   = low_mask(pw);
        msb = |(p & (XW'(1) << (pw - 1)));
        return (sgn && msb) ? (p | ~m) : (p & m);
    endfunction

    // w-bit add with overflow flag; the result is confined to the low w bits.
    function automatic logic [XW-1:0] add_ovf(input  logic [XW-1:0] a,
                                              input  logic [XW-1:0] b,
                                              input  int unsigned   w,
                                              input  logic          sgn,
                                              output logic          ovf);
        logic [XW-1:0] m;
        logic [XW-1:0] top;
        logic [XW-1:0] sum;
        m   = low_mask(w);
        top = XW'(1) << (w - 1);
        sum = (a & m) + (b & m);
        if (sgn) begin
            ovf = ((a & top) == (b & top)) && ((sum & top) != (a & top));
        end else begin
            ovf = (sum & ~m) != '0;
        end
`ifdef MAC_SAT_EN
        // Clamp toward the side the operands pushed: min is 100..0, max is 011..1 (signed) or 11..1.
        if (ovf) begin
            sum = sgn ? (((a & top) != '0) ? top : (m >> 1)) : m;
        end
`endif
        return sum & m;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered DATA_WIDTH x DATA_WIDTH multiplier with a valid tag; one cycle latency, no backpressure.
// The product is 2*DATA_WIDTH wide and held between valid beats.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int SIGNED     = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_vld,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    output logic                    out_vld,
    output logic [2*DATA_WIDTH-1:0] out_prod
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] prod_d;
    logic [PW-1:0] prod_q;
    logic          vld_d;
    logic          vld_q;

    // Multiplying the extended operands modulo 2^PW yields the exact two's-complement product.
    always_comb begin
        a_ext  = {{DATA_WIDTH{(SIGNED != 0) & in_a[DATA_WIDTH-1]}}, in_a};
        b_ext  = {{DATA_WIDTH{(SIGNED != 0) & in_b[DATA_WIDTH-1]}}, in_b};
        prod_d = in_vld ? (a_ext * b_ext) : prod_q;
        vld_d  = in_vld;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_prod = prod_q;

endmodule

// File: rtl/mac_dot_pipe.sv
// Dot-product MAC: cfg_len (a,b) products summed onto bias; MAC_SAT_EN selects saturating accumulation.
// Result valid on the 2nd edge after the last beat; in_ready low from then until the result is taken.
module mac_dot_pipe
    import mac_pkg::*;
#(
    parameter int   DATA_WIDTH = 4,
    parameter int   ACC_WIDTH  = 16,
    parameter int   MAX_LEN    = 16,
    parameter int   SIGNED     = 0,
    localparam int  LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_ovf
);

    localparam int PW = 2 * DATA_WIDTH;

    generate
        if (ACC_WIDTH < PW || ACC_WIDTH >= XW) begin : g_bad_width
            $error("mac_dot_pipe: ACC_WIDTH must be >= 2*DATA_WIDTH and < 64");
        end
    endgenerate

    mac_state_t            state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
    logic                  out_ovf_q, out_ovf_d;

    logic                  beat_acc;
    logic                  prod_vld;
    logic [PW-1:0]         prod;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  sum_val;
    logic                  add_of;
    logic [LEN_W-1:0]      eff_len;

    assign in_ready = reset_n && (state_q == IDLE || state_q == ACCUM);
    assign beat_acc = in_valid && in_ready;

    mac_mult_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mult (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (beat_acc),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_vld  (prod_vld),
        .out_prod (prod)
    );

    always_comb begin
        if (cfg_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (cfg_len > LEN_W'(MAX_LEN)) begin
            eff_len = LEN_W'(MAX_LEN);
        end else begin
            eff_len = cfg_len;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        add_of      = 1'b0;

        prod_ext = ACC_WIDTH'(ext_prod(XW'(prod), PW, SIGNED != 0));
        sum_val  = ACC_WIDTH'(add_ovf(XW'(acc_q), XW'(prod_ext), ACC_WIDTH, SIGNED != 0, add_of));

        // The registered product of each beat lands one edge behind its handshake.
        if (prod_vld) begin
            acc_d = sum_val;
            ovf_d = ovf_q | add_of;
        end

        unique case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    len_d   = eff_len;
                    cnt_d   = LEN_W'(1);
                    acc_d   = bias;
                    ovf_d   = 1'b0;
                    state_d = (eff_len == LEN_W'(1)) ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Publish only once the last product has been folded into acc.
                if (!prod_vld) begin
                    out_data_d  = acc_q;
                    out_ovf_d   = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule
